fetch_hazard_ctrl: RTL and testbench
====================================

# fetch_hazard_ctrl

Sequencing controller for the instruction-fetch stage of the 5-stage LEGv8 pipeline. Every cycle it decides whether the PC and IF/ID register advance, hold, or are redirected to a branch target. It detects load-use hazards between ID and EX, squashes the wrong-path fetch on a taken branch resolved in ID, and honours external stall and halt requests. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rn, id_rm  in  5 each  source registers of the instruction in ID
- id_uses_rn, id_uses_rm  in  1 each  ID instruction reads Rn / Rm
- ex_memread  in  1  instruction in EX is an LDUR
- ex_rd  in  5  destination register of the instruction in EX
- br_taken  in  1  branch in ID resolved taken (B, CBZ, B.LT)
- br_is_b  in  1  1 selects the B target, 0 selects the CBZ/B.LT target
- ext_stall  in  1  data memory busy; freeze the front end
- halt_req  in  1  request permanent halt
- pc_we  out  1  PC write enable
- pc_sel  out  2  PC source: 0 = PC+4, 1 = B target, 2 = CBZ target
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  load a NOP into IF/ID
- idex_bubble  out  1  insert a NOP into ID/EX
- halted  out  1  registered; controller is in HALT
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

## Operation
- FSM states: INIT, RUN, HALT.
- **INIT**
  - Entered asynchronously on reset; lasts exactly one cycle after reset deasserts.
  - Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
  - Next state: RUN.
- **RUN.** Decisions in strict priority order, first match wins:
  1. ext_stall=1: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0. All stages hold; stall_cnt increments.
  2. Load-use hazard: ex_memread=1, ex_rd≠31, and (id_uses_rn and id_rn==ex_rd, or id_uses_rm and id_rm==ex_rd). Response: pc_we=0, ifid_we=0, idex_bubble=1. Any br_taken in this cycle is ignored. stall_cnt increments.
  3. halt_req=1: pc_we=0, ifid_we=0, idex_bubble=1. Next state is HALT.
  4. br_taken=1: pc_we=1, pc_sel = br_is_b ? 1 : 2, ifid_we=1, ifid_flush=1, idex_bubble=0. flush_cnt increments.
  5. Otherwise: pc_we=1, pc_sel=0, ifid_we=1, all other outputs 0.
- Register 31 (XZR) never creates a hazard.
- **HALT**
  - Absorbing state; only reset exits it.
  - Outputs: pc_we=0, ifid_we=0, idex_bubble=1, halted=1.
  - Counters freeze.
- Counters saturate at 2^CNT_W−1 and never wrap.
- pc_sel=3 is never driven.

## Timing
- All control outputs except halted and the counters are combinational from state and inputs (Mealy), valid in the same cycle as the inputs.
- halted, the counters and the state update on the rising clk edge.
- Reset values: state INIT, pc_we=0, pc_sel=0, ifid_we=0, ifid_flush=0, idex_bubble=1, halted=0, stall_cnt=0, flush_cnt=0.
- Load-use costs exactly one bubble. In the next cycle the load has moved to MEM, so detection deasserts without any extra state.
- A taken branch costs one flushed slot. The redirected fetch happens in the cycle after br_taken.
- ext_stall and load-use in the same cycle: ext_stall wins. The hazard is re-evaluated once ext_stall drops.
- Reset asserted mid-stall or mid-branch: state and outputs go to reset values immediately, with no clock required.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum {INIT, RUN, HALT}
  - pc_sel encodings PCSEL_SEQ=0, PCSEL_B=1, PCSEL_CBZ=2
  - constant XZR=5'd31
- One sub-module, sat_counter: parameterised width, inputs inc and async active-low reset. Instantiated twice, for stall_cnt and flush_cnt.

## Test plan
- **Reset then run:** release reset → one cycle with pc_we=0, idex_bubble=1; then pc_we=1, pc_sel=0 every cycle; all counters stay 0.
- **Load-use:** ex_memread=1, ex_rd=5, id_rn=5, id_uses_rn=1 for one cycle → pc_we=0, ifid_we=0, idex_bubble=1 in that cycle, stall_cnt=1. Repeating the test with ex_rd=id_rn=31 gives no stall.
- **Branch during load-use:** the same hazard plus br_taken=1 → stall response, pc_sel=0, flush_cnt unchanged.
- **Taken branches:**
  - br_taken=1, br_is_b=0 → pc_sel=2, ifid_flush=1, flush_cnt=1.
  - Next cycle br_taken=1, br_is_b=1 → pc_sel=1, flush_cnt=2.
- **ext_stall overlapping load-use, then halt:**
  - Both asserted for 3 cycles → idex_bubble=0 throughout, stall_cnt=3.
  - Drop ext_stall → one load-use bubble.
  - halt_req=1 → halted=1 next cycle and stays 1. Low reset mid-halt clears it asynchronously.
- **Saturation:** with CNT_W=4, hold ext_stall for 20 cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the LEGv8 pipeline front-end
//               control logic: controller state enum, PC source selector
//               encodings and the zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Front-end controller states
    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // PC source selector encodings (value 3 is never driven)
    localparam logic [1:0] PCSEL_SEQ = 2'd0;   // PC + 4
    localparam logic [1:0] PCSEL_B   = 2'd1;   // unconditional B target
    localparam logic [1:0] PCSEL_CBZ = 2'd2;   // CBZ / B.cond target

    // XZR reads as zero and is never a real producer
    localparam logic [4:0] XZR = 5'd31;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Used for front-end performance debug counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-low reset (clears count)
//   inc    in   1      increment request for this cycle
//   count  out  WIDTH  current count value
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hazard_ctrl
// Description : Instruction-fetch sequencing controller for the 5-stage
//               LEGv8 pipeline. Each cycle decides whether PC and IF/ID
//               advance, hold or redirect; detects ID/EX load-use hazards,
//               squashes the wrong-path fetch on taken branches, honours
//               external stall and halt, and keeps saturating stall/flush
//               counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   id_rn/id_rm  in   5      source registers of the ID instruction
//   id_uses_rn/m in   1      ID instruction actually reads Rn / Rm
//   ex_memread   in   1      EX instruction is a load
//   ex_rd        in   5      EX destination register
//   br_taken     in   1      branch in ID resolved taken
//   br_is_b      in   1      1 = B target, 0 = CBZ/B.cond target
//   ext_stall    in   1      data memory busy, freeze front end
//   halt_req     in   1      request permanent halt
//   pc_we        out  1      PC write enable            (combinational)
//   pc_sel       out  2      PC source select           (combinational)
//   ifid_we      out  1      IF/ID write enable         (combinational)
//   ifid_flush   out  1      load NOP into IF/ID        (combinational)
//   idex_bubble  out  1      insert NOP into ID/EX      (combinational)
//   halted       out  1      controller is in HALT      (registered)
//   stall_cnt    out  CNT_W  saturating stall counter   (registered)
//   flush_cnt    out  CNT_W  saturating flush counter   (registered)
// ============================================================================
module fetch_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    input  logic             br_is_b,
    input  logic             ext_stall,
    input  logic             halt_req,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t r_state;
    state_t w_next_state;
    logic   r_halted;
    logic   w_load_use;
    logic   w_stall_inc;
    logic   w_flush_inc;

    // A load in EX whose destination feeds an operand of the ID instruction.
    // XZR is excluded: a load into XZR discards its data, so nothing waits.
    assign w_load_use = ex_memread && (ex_rd != XZR) &&
                        ((id_uses_rn && (id_rn == ex_rd)) ||
                         (id_uses_rm && (id_rm == ex_rd)));

    // ------------------------------------------------------------------
    // State and halted flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= INIT;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == HALT);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Mealy control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        pc_we        = 1'b0;
        pc_sel       = PCSEL_SEQ;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        case (r_state)
            INIT: begin
                // Keep the back end fed with NOPs for the first cycle.
                idex_bubble  = 1'b1;
                w_next_state = RUN;
            end

            RUN: begin
                if (ext_stall) begin
                    // Whole pipe frozen; ID/EX must hold too, so no bubble.
                    w_stall_inc = 1'b1;
                end else if (w_load_use) begin
                    // Hold IF and ID for one cycle; a pending branch in ID
                    // is ignored because its operands are not ready yet.
                    idex_bubble = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (halt_req) begin
                    idex_bubble  = 1'b1;
                    w_next_state = HALT;
                end else if (br_taken) begin
                    pc_we       = 1'b1;
                    pc_sel      = br_is_b ? PCSEL_B : PCSEL_CBZ;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    w_flush_inc = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end

            HALT: begin
                idex_bubble = 1'b1;
            end

            default: begin
                // Unreachable encoding; recover through INIT.
                idex_bubble  = 1'b1;
                w_next_state = INIT;
            end
        endcase
    end

    assign halted = r_halted;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule : fetch_hazard_ctrl
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_hazard_ctrl
// Description : Self-checking bench for fetch_hazard_ctrl. Directed scenarios
//               followed by randomized traffic; expected responses come from
//               a behavioural model and are queued to an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_hazard_ctrl;

    localparam int W    = 4;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   id_rn, id_rm, ex_rd;
    logic         id_uses_rn, id_uses_rm, ex_memread;
    logic         br_taken, br_is_b, ext_stall, halt_req;
    logic         pc_we, ifid_we, ifid_flush, idex_bubble, halted;
    logic [1:0]   pc_sel;
    logic [W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(
        .CNT_W (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rn  (id_uses_rn),
        .id_uses_rm  (id_uses_rm),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .br_taken    (br_taken),
        .br_is_b     (br_is_b),
        .ext_stall   (ext_stall),
        .halt_req    (halt_req),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    typedef struct packed {
        logic         pc_we;
        logic [1:0]   pc_sel;
        logic         ifid_we;
        logic         ifid_flush;
        logic         idex_bubble;
        logic         halted;
        logic [W-1:0] stall_cnt;
        logic [W-1:0] flush_cnt;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: has the controller finished its post-reset cycle,
    // has it halted, and the running event tallies.
    bit   m_live  = 1'b0;
    bit   m_halt  = 1'b0;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic set_idle();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
        id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_memread = 1'b0;
        br_taken = 1'b0; br_is_b = 1'b0; ext_stall = 1'b0; halt_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them,
    // then advance the model across the coming clock edge.
    task automatic apply();
        obs_t e;
        bit   hz, inc_s, inc_f, go_halt;
        if (!reset) begin
            m_live = 1'b0; m_halt = 1'b0; m_stall = 0; m_flush = 0;
        end
        hz = ex_memread && (ex_rd != 5'd31) &&
             ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
        inc_s = 1'b0; inc_f = 1'b0; go_halt = 1'b0;
        e = '0;
        e.halted    = m_halt;
        e.stall_cnt = W'(m_stall);
        e.flush_cnt = W'(m_flush);
        if (m_halt || !m_live) begin
            e.idex_bubble = 1'b1;
        end else if (ext_stall) begin
            inc_s = 1'b1;
        end else if (hz) begin
            e.idex_bubble = 1'b1;
            inc_s = 1'b1;
        end else if (halt_req) begin
            e.idex_bubble = 1'b1;
            go_halt = 1'b1;
        end else if (br_taken) begin
            e.pc_we = 1'b1; e.ifid_we = 1'b1; e.ifid_flush = 1'b1;
            e.pc_sel = br_is_b ? 2'd1 : 2'd2;
            inc_f = 1'b1;
        end else begin
            e.pc_we = 1'b1; e.ifid_we = 1'b1;
        end
        exp_q.push_back(e);
        if (reset) begin
            m_live = 1'b1;
            if (go_halt) m_halt = 1'b1;
            if (inc_s && m_stall < CMAX) m_stall++;
            if (inc_f && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic load_use(input logic [4:0] r);
        ex_memread = 1'b1; ex_rd = r; id_rn = r; id_uses_rn = 1'b1;
    endtask

    // Monitor: compare one queued expectation per cycle, mid-cycle.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.pc_we = pc_we; a.pc_sel = pc_sel; a.ifid_we = ifid_we;
                a.ifid_flush = ifid_flush; a.idex_bubble = idex_bubble;
                a.halted = halted; a.stall_cnt = stall_cnt; a.flush_cnt = flush_cnt;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got pc_we=%b sel=%0d ifid_we=%b flush=%b bub=%b halted=%b scnt=%0d fcnt=%0d ; want pc_we=%b sel=%0d ifid_we=%b flush=%b bub=%b halted=%b scnt=%0d fcnt=%0d",
                             vectors, $time, a.pc_we, a.pc_sel, a.ifid_we, a.ifid_flush,
                             a.idex_bubble, a.halted, a.stall_cnt, a.flush_cnt,
                             e.pc_we, e.pc_sel, e.ifid_we, e.ifid_flush,
                             e.idex_bubble, e.halted, e.stall_cnt, e.flush_cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_idle();

        // Reset state, then first cycle after release, then free run
        next_cycle(); apply();
        next_cycle(); reset = 1'b1; apply();
        repeat (3) begin next_cycle(); apply(); end

        // Load-use on Rn, then counter visible
        next_cycle(); load_use(5'd5); apply();
        next_cycle(); set_idle(); apply();
        // Same through XZR: no stall
        next_cycle(); load_use(5'd31); apply();
        // Load-use on Rm
        next_cycle(); set_idle(); ex_memread = 1'b1; ex_rd = 5'd9;
        id_rm = 5'd9; id_uses_rm = 1'b1; apply();
        // Branch during load-use is ignored
        next_cycle(); set_idle(); load_use(5'd5); br_taken = 1'b1; apply();
        // Taken branches, CBZ then B
        next_cycle(); set_idle(); br_taken = 1'b1; br_is_b = 1'b0; apply();
        next_cycle(); br_is_b = 1'b1; apply();
        next_cycle(); set_idle(); apply();

        // ext_stall overlapping load-use, then hazard alone, then halt
        next_cycle(); load_use(5'd7); ext_stall = 1'b1; apply();
        repeat (2) begin next_cycle(); apply(); end
        next_cycle(); ext_stall = 1'b0; apply();
        next_cycle(); set_idle(); apply();
        next_cycle(); halt_req = 1'b1; apply();
        next_cycle(); halt_req = 1'b0; br_taken = 1'b1; apply();
        repeat (3) begin next_cycle(); apply(); end
        // Asynchronous reset mid-halt
        next_cycle(); set_idle(); reset = 1'b0; apply();
        next_cycle(); reset = 1'b1; apply();

        // Saturation: 20 cycles of ext_stall
        next_cycle(); apply();
        repeat (20) begin next_cycle(); ext_stall = 1'b1; apply(); end
        next_cycle(); set_idle(); apply();
        // Branch burst to saturate flush counter, reset mid-branch
        repeat (18) begin next_cycle(); br_taken = 1'b1; br_is_b = 1'($urandom_range(0, 1)); apply(); end
        next_cycle(); reset = 1'b0; apply();
        next_cycle(); set_idle(); reset = 1'b1; apply();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            next_cycle();
            reset      = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            ex_rd      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rn      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rm      = 5'($urandom_range(0, 3));
            id_uses_rn = 1'($urandom_range(0, 1));
            id_uses_rm = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 2) == 0);
            br_taken   = ($urandom_range(0, 4) < 2);
            br_is_b    = 1'($urandom_range(0, 1));
            ext_stall  = ($urandom_range(0, 4) == 0);
            halt_req   = ($urandom_range(0, 49) == 0);
            apply();
        end

        next_cycle(); set_idle(); reset = 1'b1;
        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_hazard_ctrl
`default_nettype wire
